// File: rtl/ica_bus_arbiter.sv
// Two-unit burst-read arbiter: grants one ICA/DCA control unit at a time, forwards its
// address/strobe to the memory port and steers valid/ack back to the owning unit only.
module ica_bus_arbiter #(
  parameter bit FIXED_PRIO  = 1'b0,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0][21:0] req_address,
  input  logic [1:0]       req_as,
  output logic [1:0]       req_ack,
  output logic [1:0]       req_valid,
  output logic [15:0]      req_din,
  output logic [21:0]      mem_address,
  output logic             mem_as,
  input  logic [15:0]      mem_din,
  input  logic             mem_valid,
  input  logic             mem_ack,
  output logic             owner,
  output logic             busy,
  output logic             timeout_err
);

  localparam int NUM_UNITS = 2;

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t     state, state_nxt;
  logic       grant;
  logic       winner;
  logic [7:0] timer;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    winner    = owner;
    case (state)
      IDLE: begin
        if (|req_as) begin
          grant     = 1'b1;
          state_nxt = BUSY;
          // Contention: fixed priority to unit 0, else hand the bus to the other unit.
          if (req_as == 2'b11) winner = FIXED_PRIO ? 1'b0 : ~owner;
          else                 winner = req_as[1];
        end
      end
      BUSY:    if (mem_ack) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mem_as      <= 1'b0;
      mem_address <= '0;
      busy        <= 1'b0;
      owner       <= 1'b1;
      timeout_err <= 1'b0;
      timer       <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner       <= winner;
        mem_address <= req_address[winner];
        mem_as      <= 1'b1;
        busy        <= 1'b1;
        timer       <= '0;
      end else if (state == BUSY) begin
        if (mem_ack) begin
          mem_as <= 1'b0;
          busy   <= 1'b0;
        end
        if (timer != 8'hFF) timer <= timer + 8'd1;
        // Sticky; the grant itself is left in place so a late ack still completes.
        if (int'(timer) == ACK_TIMEOUT) timeout_err <= 1'b1;
      end
    end
  end

  assign req_din = mem_din;

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_route
    wire own = (state == BUSY) && (owner == 1'(u));
    assign req_valid[u] = own && mem_valid;
    assign req_ack[u]   = own && mem_ack;
  end

endmodule
